// File: rtl/mul_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_issue_arbiter
// Purpose  : Shares one pipelined multiplier between NUM_REQ reservation
//            stations. Round-robin grant, registered multiplier command, a
//            shadow tag pipeline aligned to mul_done, and an output FIFO that
//            drains to the CDB. Issue is credit-limited so a returning result
//            always has a queue slot.
// Ports    : clk, rst (sync, active-high), flush (squash in-flight work)
//            req_valid/req_ready/req_op/req_rs1/req_rs2/req_tag : requesters
//            mul_start/mul_op_sel/mul_rs1/mul_rs2 : multiplier command
//            mul_done/mul_result                  : multiplier return
//            cdb_valid/cdb_tag/cdb_result/cdb_ready : CDB handshake
//            err : sticky error, cleared only by rst
// Revision : 1.0 - initial release
// ============================================================================
module mul_issue_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int TAG_W      = 6,
    parameter int MUL_LAT    = 4,
    parameter int OUTQ_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [5*NUM_REQ-1:0]     req_op,
    input  logic [32*NUM_REQ-1:0]    req_rs1,
    input  logic [32*NUM_REQ-1:0]    req_rs2,
    input  logic [TAG_W*NUM_REQ-1:0] req_tag,
    output logic                     mul_start,
    output logic [4:0]               mul_op_sel,
    output logic [31:0]              mul_rs1,
    output logic [31:0]              mul_rs2,
    input  logic                     mul_done,
    input  logic [31:0]              mul_result,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [31:0]              cdb_result,
    input  logic                     cdb_ready,
    output logic                     err
);

    localparam int c_PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_QPTR_W = $clog2(OUTQ_DEPTH);
    localparam int c_CNT_W  = $clog2(OUTQ_DEPTH + MUL_LAT + 2);

    logic [c_PTR_W-1:0]  r_rr_ptr;
    logic                r_mul_start;
    logic [4:0]          r_mul_op;
    logic [31:0]         r_mul_rs1;
    logic [31:0]         r_mul_rs2;
    logic [TAG_W-1:0]    r_iss_tag;
    logic [MUL_LAT-1:0]  r_pipe_vld;
    logic [TAG_W-1:0]    r_pipe_tag [MUL_LAT];
    logic [MUL_LAT-1:0]  r_sq;
    logic [TAG_W-1:0]    r_q_tag [OUTQ_DEPTH];
    logic [31:0]         r_q_res [OUTQ_DEPTH];
    logic [c_QPTR_W-1:0] r_wr_ptr;
    logic [c_QPTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_q_count;
    logic                r_err;

    logic [c_CNT_W-1:0]  w_inflight;
    logic                w_credit;
    logic                w_found;
    logic [c_PTR_W:0]    w_sum;
    logic [c_PTR_W-1:0]  w_gnt_idx;
    logic [c_PTR_W-1:0]  w_rr_next;
    logic                w_hs;
    logic [4:0]          w_sel_op;
    logic                w_legal;
    logic                w_issue;
    logic                w_kill;
    logic                w_last_vld;
    logic                w_push;
    logic                w_pop;
    logic                w_push_ok;
    logic                w_set_err;

    // In-flight ops: the command register plus every valid tag stage.
    always_comb begin
        w_inflight = c_CNT_W'(r_mul_start);
        for (int k = 0; k < MUL_LAT; k++) begin
            w_inflight = w_inflight + c_CNT_W'(r_pipe_vld[k]);
        end
    end

    // Dequeues in the same cycle are not credited (conservative).
    assign w_credit = (w_inflight + r_q_count) < c_CNT_W'(OUTQ_DEPTH);

    // Round-robin search starting at r_rr_ptr.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_PTR_W+1)'(k);
            if (w_sum >= (c_PTR_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (c_PTR_W+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_sum[c_PTR_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_sum[c_PTR_W-1:0];
            end
        end
    end

    assign w_hs      = w_found & w_credit & ~flush & ~rst;
    assign w_rr_next = (w_gnt_idx == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_sel_op  = req_op[5*w_gnt_idx +: 5];
    assign w_legal   = w_sel_op[4] & ~w_sel_op[2];
    assign w_issue   = w_hs & w_legal;

    always_comb begin
        req_ready = '0;
        if (w_hs) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign w_kill     = rst | flush;
    assign w_last_vld = r_pipe_vld[MUL_LAT-1];
    assign w_push     = mul_done & w_last_vld & ~flush;
    assign w_pop      = cdb_valid & cdb_ready;
    assign w_push_ok  = w_push & ((r_q_count != c_CNT_W'(OUTQ_DEPTH)) | w_pop);

    // Illegal op consumed, spurious done outside the squash shadow, a
    // missing done for a live op, or (should credit ever fail) an overflow.
    assign w_set_err = (w_hs & ~w_legal)
                     | (mul_done & ~w_last_vld & ~r_sq[MUL_LAT-1])
                     | (~mul_done & w_last_vld)
                     | (w_push & ~w_push_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_mul_start <= 1'b0;
            r_mul_op    <= '0;
            r_mul_rs1   <= '0;
            r_mul_rs2   <= '0;
            r_iss_tag   <= '0;
            r_pipe_vld  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_q_count   <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_hs) begin
                r_rr_ptr <= w_rr_next;
            end
            r_mul_start <= w_issue;
            if (w_issue) begin
                r_mul_op  <= w_sel_op;
                r_mul_rs1 <= req_rs1[32*w_gnt_idx +: 32];
                r_mul_rs2 <= req_rs2[32*w_gnt_idx +: 32];
                r_iss_tag <= req_tag[TAG_W*w_gnt_idx +: TAG_W];
            end
            if (flush) begin
                r_pipe_vld <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_q_count  <= '0;
            end else begin
                r_pipe_vld[0] <= r_mul_start;
                for (int k = 1; k < MUL_LAT; k++) begin
                    r_pipe_vld[k] <= r_pipe_vld[k-1];
                end
                if (w_push_ok) begin
                    r_wr_ptr <= (r_wr_ptr == c_QPTR_W'(OUTQ_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= (r_rd_ptr == c_QPTR_W'(OUTQ_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
                end
                r_q_count <= r_q_count + c_CNT_W'(w_push_ok) - c_CNT_W'(w_pop);
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Squash shadow: on flush or reset, every op that was in flight is
    // marked here and travels alongside its (now cleared) tag stage, so its
    // mul_done lands on a set shadow bit and is dropped without error.
    // Deliberately not reset: reset itself must load the shadow.
    always_ff @(posedge clk) begin
        r_sq[0] <= w_kill & r_mul_start;
        for (int k = 1; k < MUL_LAT; k++) begin
            r_sq[k] <= r_sq[k-1] | (w_kill & r_pipe_vld[k-1]);
        end
    end

    // Data-only storage: tags and queue entries qualified by valids/count.
    always_ff @(posedge clk) begin
        r_pipe_tag[0] <= r_iss_tag;
        for (int k = 1; k < MUL_LAT; k++) begin
            r_pipe_tag[k] <= r_pipe_tag[k-1];
        end
        if (w_push_ok) begin
            r_q_tag[r_wr_ptr] <= r_pipe_tag[MUL_LAT-1];
            r_q_res[r_wr_ptr] <= mul_result;
        end
    end

    assign mul_start  = r_mul_start;
    assign mul_op_sel = r_mul_op;
    assign mul_rs1    = r_mul_rs1;
    assign mul_rs2    = r_mul_rs2;
    assign cdb_valid  = (r_q_count != '0);
    assign cdb_tag    = cdb_valid ? r_q_tag[r_rd_ptr] : '0;
    assign cdb_result = cdb_valid ? r_q_res[r_rd_ptr] : '0;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_issue_arbiter
// Purpose  : Self-checking bench for mul_issue_arbiter. Contains a behavioural
//            MUL_LAT-cycle multiplier, a table of single-op vectors and
//            hand-written sequences for arbitration, credit, flush, illegal
//            op and spurious-done cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_issue_arbiter;

    localparam int NUM_REQ    = 2;
    localparam int TAG_W      = 6;
    localparam int MUL_LAT    = 4;
    localparam int OUTQ_DEPTH = 4;

    localparam logic [4:0] c_MUL    = 5'b10000;
    localparam logic [4:0] c_MULH   = 5'b10001;
    localparam logic [4:0] c_MULHSU = 5'b10010;
    localparam logic [4:0] c_MULHU  = 5'b10011;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [5*NUM_REQ-1:0]     req_op;
    logic [32*NUM_REQ-1:0]    req_rs1;
    logic [32*NUM_REQ-1:0]    req_rs2;
    logic [TAG_W*NUM_REQ-1:0] req_tag;
    logic                     mul_start;
    logic [4:0]               mul_op_sel;
    logic [31:0]              mul_rs1;
    logic [31:0]              mul_rs2;
    logic                     mul_done;
    logic [31:0]              mul_result;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [31:0]              cdb_result;
    logic                     cdb_ready;
    logic                     err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_issue_arbiter #(
        .NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT), .OUTQ_DEPTH(OUTQ_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .mul_start(mul_start), .mul_op_sel(mul_op_sel),
        .mul_rs1(mul_rs1), .mul_rs2(mul_rs2),
        .mul_done(mul_done), .mul_result(mul_result),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result),
        .cdb_ready(cdb_ready), .err(err)
    );

    // Behavioural multiplier: fixed latency, no flush, no stall.
    logic [MUL_LAT-1:0] m_vld = '0;
    logic [31:0]        m_res [MUL_LAT];
    logic               inj_done;

    function automatic logic [31:0] mul_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] p;
        logic [63:0]        u;
        sa = {{32{a[31]}}, a};
        u  = {32'b0, a} * {32'b0, b};
        case (op[1:0])
            2'd0:    return u[31:0];
            2'd1:    begin sb = {{32{b[31]}}, b}; p = sa * sb; return p[63:32]; end
            2'd2:    begin sb = {32'b0, b};       p = sa * sb; return p[63:32]; end
            default: return u[63:32];
        endcase
    endfunction

    always @(posedge clk) begin
        m_vld[0] <= mul_start;
        m_res[0] <= mul_model(mul_op_sel, mul_rs1, mul_rs2);
        for (int k = 1; k < MUL_LAT; k++) begin
            m_vld[k] <= m_vld[k-1];
            m_res[k] <= m_res[k-1];
        end
    end

    assign mul_done   = m_vld[MUL_LAT-1] | inj_done;
    assign mul_result = m_res[MUL_LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] tag);
        req_op[5*r +: 5]          = op;
        req_rs1[32*r +: 32]       = a;
        req_rs2[32*r +: 32]       = b;
        req_tag[TAG_W*r +: TAG_W] = tag;
    endtask

    // One op from requester r, checked at c, c+1 and c+6. Entered just after
    // a rising edge; leaves just after the edge that pops the result.
    task automatic run_single(input string name, input int r, input logic [4:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [TAG_W-1:0] tag, input logic [31:0] exp);
        int n_early;
        req_valid    = '0;
        req_valid[r] = 1'b1;
        set_req(r, op, a, b, tag);
        @(negedge clk);
        check({name, " ready"}, 64'(req_ready), 64'(1) << r);
        tick();
        req_valid = '0;
        @(negedge clk);
        check({name, " start"}, 64'(mul_start), 64'(1));
        check({name, " op_sel"}, 64'(mul_op_sel), 64'(op));
        check({name, " rs1"}, 64'(mul_rs1), 64'(a));
        check({name, " rs2"}, 64'(mul_rs2), 64'(b));
        n_early = 0;
        for (int k = 2; k <= 5; k++) begin
            tick();
            @(negedge clk);
            if (cdb_valid) n_early++;
        end
        check({name, " early cdb"}, 64'(n_early), 64'(0));
        tick();
        @(negedge clk);
        check({name, " cdb_valid"}, 64'(cdb_valid), 64'(1));
        check({name, " cdb_tag"}, 64'(cdb_tag), 64'(tag));
        check({name, " cdb_result"}, 64'(cdb_result), 64'(exp));
        check({name, " err"}, 64'(err), 64'(0));
        tick();
    endtask

    typedef struct {
        int               r;
        logic [4:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TAG_W-1:0] exp_tag [4];
        logic [31:0]      exp_res [4];
        int               got;
        int               grants;
        int               kk;
        int               cnt;
        logic             g;

        vecs[0] = '{0, c_MUL,    32'd10,        32'hFFFFFFFB, 6'd5,  32'hFFFFFFCE};
        vecs[1] = '{1, c_MUL,    32'd3,         32'd4,        6'd9,  32'h0000000C};
        vecs[2] = '{0, c_MULH,   32'h7FFFFFFF,  32'h7FFFFFFF, 6'd12, 32'h3FFFFFFF};
        vecs[3] = '{1, c_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 6'd33, 32'hFFFFFFFE};
        vecs[4] = '{0, c_MULHSU, 32'hFFFFFFFF,  32'd2,        6'd63, 32'hFFFFFFFF};
        vecs[5] = '{1, c_MULH,   32'hFFFFFFFE,  32'hFFFFFFFE, 6'd1,  32'h00000000};

        // Reset with requests pending: no grant, all outputs cleared.
        rst       = 1'b1;
        flush     = 1'b0;
        inj_done  = 1'b0;
        cdb_ready = 1'b1;
        req_valid = '1;
        req_op    = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_tag   = '0;
        set_req(0, c_MUL, 32'd1, 32'd2, 6'd3);
        set_req(1, c_MUL, 32'd4, 32'd5, 6'd6);
        repeat (3) tick();
        @(negedge clk);
        check("rst req_ready", 64'(req_ready), 64'(0));
        check("rst mul_start", 64'(mul_start), 64'(0));
        check("rst mul_op_sel", 64'(mul_op_sel), 64'(0));
        check("rst mul_rs1", 64'(mul_rs1), 64'(0));
        check("rst mul_rs2", 64'(mul_rs2), 64'(0));
        check("rst cdb_valid", 64'(cdb_valid), 64'(0));
        check("rst cdb_tag", 64'(cdb_tag), 64'(0));
        check("rst cdb_result", 64'(cdb_result), 64'(0));
        check("rst err", 64'(err), 64'(0));
        tick();
        rst       = 1'b0;
        req_valid = '0;
        repeat (MUL_LAT + 2) tick();

        for (int i = 0; i < 6; i++) begin
            run_single($sformatf("vec%0d", i), vecs[i].r, vecs[i].op, vecs[i].a,
                       vecs[i].b, vecs[i].tag, vecs[i].exp);
        end

        // Two requesters contending: rr_ptr is 0 after vec5 (requester 1).
        exp_tag = '{6'd10, 6'd11, 6'd12, 6'd13};
        exp_res = '{32'h0000000C, 32'h0000001E, 32'h3FFFFFFF, 32'h00000000};
        set_req(0, c_MUL, 32'd3, 32'd4, 6'd10);
        set_req(1, c_MUL, 32'd5, 32'd6, 6'd11);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("alt grant%0d", i), 64'(req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
            tick();
            if (i == 0) set_req(0, c_MULH, 32'h7FFFFFFF, 32'h7FFFFFFF, 6'd12);
            if (i == 1) set_req(1, c_MULH, 32'hFFFFFFFE, 32'hFFFFFFFE, 6'd13);
        end
        req_valid = '0;
        got = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (cdb_valid) begin
                if (got < 4) begin
                    check($sformatf("alt tag%0d", got), 64'(cdb_tag), 64'(exp_tag[got]));
                    check($sformatf("alt res%0d", got), 64'(cdb_result), 64'(exp_res[got]));
                end
                got++;
            end
            tick();
        end
        check("alt count", 64'(got), 64'(4));

        // Credit exhaustion with the CDB stalled.
        cdb_ready = 1'b0;
        kk        = 0;
        grants    = 0;
        set_req(0, c_MUL, 32'd1, 32'd7, 6'd20);
        req_valid = 2'b01;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            g = req_ready[0];
            if (g) grants++;
            tick();
            if (g) begin
                kk++;
                set_req(0, c_MUL, 32'(kk + 1), 32'd7, 6'(20 + kk));
            end
        end
        check("stall grants", 64'(grants), 64'(OUTQ_DEPTH));
        @(negedge clk);
        check("stall ready", 64'(req_ready), 64'(0));
        check("stall cdb_valid", 64'(cdb_valid), 64'(1));
        check("stall tag", 64'(cdb_tag), 64'(20));
        tick();
        @(negedge clk);
        check("stall hold tag", 64'(cdb_tag), 64'(20));
        check("stall hold res", 64'(cdb_result), 64'(7));
        tick();
        cdb_ready = 1'b1;
        got       = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (cdb_valid) begin
                check($sformatf("drain tag%0d", got), 64'(cdb_tag), 64'(20 + got));
                check($sformatf("drain res%0d", got), 64'(cdb_result), 64'((got + 1) * 7));
                got++;
            end
            g = req_ready[0];
            if (g) grants++;
            tick();
            if (g) begin
                if (grants < 6) begin
                    kk++;
                    set_req(0, c_MUL, 32'(kk + 1), 32'd7, 6'(20 + kk));
                end else begin
                    req_valid = '0;
                end
            end
        end
        check("drain count", 64'(got), 64'(6));
        check("resume grants", 64'(grants), 64'(6));

        // Flush two cycles after three back-to-back issues.
        req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            set_req(0, c_MUL, 32'(50 + i), 32'd3, 6'(40 + i));
            @(negedge clk);
            check($sformatf("flush iss%0d", i), 64'(req_ready), 64'(1));
            tick();
        end
        req_valid = '0;
        tick();
        flush     = 1'b1;
        req_valid = 2'b01;
        set_req(0, c_MUL, 32'd9, 32'd9, 6'd44);
        @(negedge clk);
        check("flush no grant", 64'(req_ready), 64'(0));
        tick();
        flush = 1'b0;
        run_single("post flush", 0, c_MUL, 32'd6, 32'hFFFFFFF9, 6'd45, 32'hFFFFFFD6);
        @(negedge clk);
        check("flush q empty", 64'(cdb_valid), 64'(0));
        check("flush err", 64'(err), 64'(0));
        tick();

        // Illegal op: consumed, nothing issued, sticky err.
        set_req(0, 5'b00011, 32'd1, 32'd2, 6'd3);
        req_valid = 2'b01;
        @(negedge clk);
        check("ill ready", 64'(req_ready), 64'(1));
        check("ill err pre", 64'(err), 64'(0));
        tick();
        req_valid = '0;
        @(negedge clk);
        check("ill start", 64'(mul_start), 64'(0));
        check("ill err", 64'(err), 64'(1));
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            @(negedge clk);
            if (cdb_valid || mul_start) cnt++;
        end
        check("ill no output", 64'(cnt), 64'(0));
        check("ill err sticky", 64'(err), 64'(1));
        tick();

        // Reset clears err; then a spurious done with nothing in flight.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst2 err", 64'(err), 64'(0));
        repeat (MUL_LAT + 2) tick();
        inj_done = 1'b1;
        @(negedge clk);
        check("spur err pre", 64'(err), 64'(0));
        tick();
        inj_done = 1'b0;
        @(negedge clk);
        check("spur err", 64'(err), 64'(1));
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (cdb_valid) cnt++;
            tick();
            @(negedge clk);
        end
        check("spur no cdb", 64'(cnt), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
